// File: rtl/key_pkg.sv
// key_pkg: shared types, default timing constants and sizing helper for the
// multi-channel key front end.
//   key_state_e       per-channel event FSM state (KEY_IDLE, KEY_PRESS, KEY_HOLD)
//   DEF_*_CYCLES      default timing at 50 MHz (20 ms debounce, 1 s long, 200 ms repeat)
//   hold_cnt_width()  width of the hold counter for a given long/repeat timing
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_PRESS = 2'd1,
        KEY_HOLD  = 2'd2
    } key_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
    localparam int unsigned DEF_LONG_CYCLES     = 32'd50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 32'd10000000;

    // clog2(max(long, repeat, 1)) + 1; the extra bit keeps the compare values
    // representable even when a count is an exact power of two.
    function automatic int unsigned hold_cnt_width(input int unsigned long_c,
                                                   input int unsigned rep_c);
        int unsigned m;
        m = long_c;
        if (rep_c > m) m = rep_c;
        if (m < 32'd1) m = 32'd1;
        return $clog2(m) + 32'd1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one key channel -- two-flop synchroniser, debounce counter,
// IDLE/PRESS/HOLD event FSM and registered one-cycle event pulses.
// Ports:
//   sys_clk       in   system clock, rising edge
//   sys_rst       in   asynchronous reset, active-high
//   key_raw       in   raw key pin, asynchronous
//   pressed_lvl   out  debounced pressed level, 1 = pressed
//   pulse_down    out  1-cycle pulse on accepted press
//   pulse_up      out  1-cycle pulse on accepted release
//   pulse_long    out  1-cycle pulse when the hold reaches LONG_CYCLES
//   pulse_repeat  out  1-cycle pulse every REPEAT_CYCLES after pulse_long
module key_channel
    import key_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_raw,
    output logic pressed_lvl,
    output logic pulse_down,
    output logic pulse_up,
    output logic pulse_long,
    output logic pulse_repeat
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 32'd1;
    localparam int unsigned HW = hold_cnt_width(LONG_CYCLES, REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 32'd1);
    localparam logic [HW-1:0] REP_LAST  =
        (REPEAT_CYCLES == 32'd0) ? '0 : HW'(REPEAT_CYCLES - 32'd1);
    localparam bit            REP_EN    = (REPEAT_CYCLES != 32'd0);

    // Pin level when the key is not pressed.
    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic          sync_meta;
    logic          sync_out;
    logic          deb_lvl;
    logic [DW-1:0] deb_cnt;
    logic          pressed;

    key_state_e    state;
    logic [HW-1:0] hold_cnt;

    // Synchroniser and debounce: deb_lvl only follows sync_out after
    // DEBOUNCE_CYCLES consecutive mismatching edges.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_meta <= IDLE_LVL;
            sync_out  <= IDLE_LVL;
            deb_lvl   <= IDLE_LVL;
            deb_cnt   <= '0;
        end else begin
            sync_meta <= key_raw;
            sync_out  <= sync_meta;
            if (sync_out == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= ~deb_lvl;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign pressed     = deb_lvl ^ ACTIVE_LOW;
    assign pressed_lvl = pressed;

    // Event FSM. Release is tested first so it wins over long/repeat.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= KEY_IDLE;
            hold_cnt     <= '0;
            pulse_down   <= 1'b0;
            pulse_up     <= 1'b0;
            pulse_long   <= 1'b0;
            pulse_repeat <= 1'b0;
        end else begin
            pulse_down   <= 1'b0;
            pulse_up     <= 1'b0;
            pulse_long   <= 1'b0;
            pulse_repeat <= 1'b0;
            unique case (state)
                KEY_IDLE: begin
                    if (pressed) begin
                        pulse_down <= 1'b1;
                        hold_cnt   <= '0;
                        state      <= KEY_PRESS;
                    end
                end
                KEY_PRESS: begin
                    if (!pressed) begin
                        pulse_up <= 1'b1;
                        state    <= KEY_IDLE;
                    end else if (hold_cnt == LONG_LAST) begin
                        pulse_long <= 1'b1;
                        hold_cnt   <= '0;
                        state      <= KEY_HOLD;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                KEY_HOLD: begin
                    if (!pressed) begin
                        pulse_up <= 1'b1;
                        state    <= KEY_IDLE;
                    end else if (REP_EN && hold_cnt == REP_LAST) begin
                        pulse_repeat <= 1'b1;
                        hold_cnt     <= '0;
                    end else if (REP_EN) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                    // With repeat disabled the counter is frozen so it can never wrap.
                end
                default: begin
                    state <= KEY_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_event_detect.sv
// key_event_detect: multi-channel key front end. Each channel is synchronised,
// debounced and turned into press / release / long-press / auto-repeat pulses.
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   asynchronous reset, active-high
//   key_i       in   raw key pins, asynchronous (NUM_KEYS)
//   key_level   out  debounced pressed level, 1 = pressed
//   key_down    out  1-cycle pulse on accepted press
//   key_up      out  1-cycle pulse on accepted release
//   key_long    out  1-cycle pulse when hold reaches LONG_CYCLES
//   key_repeat  out  1-cycle pulse every REPEAT_CYCLES after key_long while held
module key_event_detect
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_up,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .key_raw      (key_i[i]),
            .pressed_lvl  (key_level[i]),
            .pulse_down   (key_down[i]),
            .pulse_up     (key_up[i]),
            .pulse_long   (key_long[i]),
            .pulse_repeat (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_event_detect.sv
// Bench for key_event_detect: an active-low 4-key build with repeat and an
// active-high 1-key build without repeat, driven by directed vectors.
module tb_key_event_detect;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] key_a   = 4'b1111;
    logic [3:0] lvl_a, down_a, up_a, long_a, rep_a;
    logic [0:0] key_b   = 1'b0;
    logic [0:0] lvl_b, down_b, up_b, long_b, rep_b;

    always #5 sys_clk = ~sys_clk;

    key_event_detect #(
        .NUM_KEYS        (4),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) u_dut_a (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_i      (key_a),
        .key_level  (lvl_a),
        .key_down   (down_a),
        .key_up     (up_a),
        .key_long   (long_a),
        .key_repeat (rep_a)
    );

    key_event_detect #(
        .NUM_KEYS        (1),
        .ACTIVE_LOW      (1'b0),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (0)
    ) u_dut_b (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_i      (key_b),
        .key_level  (lvl_b),
        .key_down   (down_b),
        .key_up     (up_b),
        .key_long   (long_b),
        .key_repeat (rep_b)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_excl  = 0;

    // Per-channel event log; index 4 is channel 0 of u_dut_b.
    int n_down[5], n_up[5], n_long[5], n_rep[5], n_lvl[5];
    int t_down[5], t_up[5], t_long[5], t_rep_first[5], t_rep_last[5];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample 1 ns later and log pulses by edge number.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 5; ch++) begin
            logic d, u, l, r, v;
            int   hits;
            if (ch < 4) begin
                d = down_a[ch]; u = up_a[ch]; l = long_a[ch]; r = rep_a[ch]; v = lvl_a[ch];
            end else begin
                d = down_b[0]; u = up_b[0]; l = long_b[0]; r = rep_b[0]; v = lvl_b[0];
            end
            hits = int'(d) + int'(u) + int'(l) + int'(r);
            if (hits > 1) n_excl++;
            if (d) begin n_down[ch]++; t_down[ch] = cyc; end
            if (u) begin n_up[ch]++;   t_up[ch]   = cyc; end
            if (l) begin n_long[ch]++; t_long[ch] = cyc; end
            if (r) begin
                if (n_rep[ch] == 0) t_rep_first[ch] = cyc;
                n_rep[ch]++;
                t_rep_last[ch] = cyc;
            end
            if (v) n_lvl[ch]++;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int c, k, r, su0, su3, sr;

        // Reset asserted between clock edges: outputs clear at once.
        #3 sys_rst = 1'b1;
        #1;
        check_eq("rst_level_a", 32'(lvl_a), 0);
        check_eq("rst_pulses_a", 32'({down_a, up_a, long_a, rep_a}), 0);
        check_eq("rst_all_b", 32'({lvl_b, down_b, up_b, long_b, rep_b}), 0);
        tick();
        tick();

        // Press key 0 together with reset release: level at edge 6, down at 7.
        sys_rst  = 1'b0;
        key_a[0] = 1'b0;
        c = cyc;
        tick_to(c + 5);
        check_eq("p0_level_e5", 32'(lvl_a[0]), 0);
        tick();
        check_eq("p0_level_e6", 32'(lvl_a[0]), 1);
        check_eq("p0_down_e6", 32'(down_a), 0);
        tick();
        check_eq("p0_down_e7", 32'(down_a), 32'b0001);
        tick();
        check_eq("p0_down_e8", 32'(down_a), 0);
        key_a[0] = 1'b1;
        c = cyc;
        tick_to(c + 7);
        check_eq("p0_up_e7", 32'(up_a), 32'b0001);
        tick_to(c + 12);
        check_eq("p0_down_n", n_down[0], 1);
        check_eq("p0_long_n", n_long[0], 0);

        // 3-cycle glitch on key 1 is swallowed.
        key_a[1] = 1'b0;
        tick();
        tick();
        tick();
        key_a[1] = 1'b1;
        tick_to(cyc + 12);
        check_eq("glitch_level", n_lvl[1], 0);
        check_eq("glitch_pulses", n_down[1] + n_up[1] + n_long[1] + n_rep[1], 0);

        // Key 2 held: long at K+20, repeats at K+28 and K+36; release lands on
        // the edge the repeat counter matches again (K+44) and must win.
        key_a[2] = 1'b0;
        c = cyc;
        k = c + 7;
        tick_to(k);
        check_eq("hold_down", 32'(down_a), 32'b0100);
        tick_to(k + 37);
        key_a[2] = 1'b1;
        r = cyc;
        tick_to(r + 10);
        check_eq("hold_long_t", t_long[2], k + 20);
        check_eq("hold_rep1_t", t_rep_first[2], k + 28);
        check_eq("hold_rep2_t", t_rep_last[2], k + 36);
        check_eq("hold_rep_n", n_rep[2], 2);
        check_eq("hold_up_t", t_up[2], r + 7);
        check_eq("hold_up_n", n_up[2], 1);

        // Release racing long: pressed falls as the counter reaches 19.
        key_a[2] = 1'b0;
        c = cyc;
        k = c + 7;
        tick_to(k + 13);
        key_a[2] = 1'b1;
        tick_to(k + 26);
        check_eq("race_down_t", t_down[2], k);
        check_eq("race_up_t", t_up[2], k + 20);
        check_eq("race_long_n", n_long[2], 1);

        // Keys 0 and 3 pressed together, then reset while in HOLD.
        key_a[0] = 1'b0;
        key_a[3] = 1'b0;
        c = cyc;
        k = c + 7;
        tick_to(k - 1);
        check_eq("sim_down_pre", 32'(down_a), 0);
        tick();
        check_eq("sim_down", 32'(down_a), 32'b1001);
        tick();
        check_eq("sim_down_post", 32'(down_a), 0);
        tick_to(k + 24);
        check_eq("sim_long3_t", t_long[3], k + 20);
        check_eq("sim_long0_n", n_long[0], 1);
        #2 sys_rst = 1'b1;
        #1;
        check_eq("sim_rst_level", 32'(lvl_a), 0);
        check_eq("sim_rst_pulses", 32'({down_a, up_a, long_a, rep_a}), 0);
        su0 = n_up[0];
        su3 = n_up[3];
        sr  = n_rep[0] + n_rep[3];
        tick();
        tick();
        sys_rst = 1'b0;
        c = cyc;
        tick_to(c + 5);
        check_eq("rel_level_e5", 32'(lvl_a), 0);
        tick();
        check_eq("rel_level_e6", 32'(lvl_a), 32'b1001);
        tick();
        check_eq("rel_down_e7", 32'(down_a), 32'b1001);
        check_eq("rel_no_up", (n_up[0] - su0) + (n_up[3] - su3), 0);
        check_eq("rel_no_rep", n_rep[0] + n_rep[3] - sr, 0);
        key_a = 4'b1111;
        tick_to(cyc + 10);
        check_eq("rel_up_n0", n_up[0] - su0, 1);

        // Active-high build without repeat.
        key_b = 1'b1;
        c = cyc;
        k = c + 7;
        tick_to(k);
        check_eq("ah_down", 32'(down_b), 1);
        tick_to(k + 40);
        key_b = 1'b0;
        r = cyc;
        tick_to(r + 10);
        check_eq("ah_long_t", t_long[4], k + 20);
        check_eq("ah_rep_n", n_rep[4], 0);
        check_eq("ah_up_t", t_up[4], r + 7);
        check_eq("ah_up_n", n_up[4], 1);
        check_eq("ah_down_n", n_down[4], 1);

        check_eq("pulse_exclusive", n_excl, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
